// File: rtl/mem_initiator.sv
// mem_initiator: turns datapath read/write/fetch requests into registered
// strobes for a two-port synchronous memory and captures the returned data.
// Port A serves mdr reads and writes; port B serves instruction fetches.
// Optional feature macro: MEM_INITIATOR_FETCH_EN compiles in the port-B fetch
// path; without it every port-B output is tied to zero.
module mem_initiator #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] mar,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] mdr_in,
    output logic              wen_A,
    output logic              ren_A,
    output logic              ren_B,
    output logic [ADDR_W-1:0] addr_A,
    output logic [ADDR_W-1:0] addr_B,
    output logic [DATA_W-1:0] wdata_A,
    input  logic [DATA_W-1:0] rdata_A,
    input  logic [DATA_W-1:0] rdata_B,
    output logic [DATA_W-1:0] mdr_out,
    output logic [DATA_W-1:0] mbr_out,
    output logic              busy_A,
    output logic              busy_B,
    output logic              rd_done,
    output logic              wr_done,
    output logic              fetch_done,
    output logic              req_err
);

    // The wait state lasts RD_LAT cycles: read data becomes valid RD_LAT
    // edges after the edge that samples the read strobe, and is captured on
    // the edge closing the last wait cycle.
    localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {A_IDLE, A_RD_ISSUE, A_RD_WAIT, A_WR_ISSUE} a_state_t;

    a_state_t          a_state_reg, a_state_next;
    logic [2:0]        a_cnt_reg, a_cnt_next;
    logic              a_capture;
    logic              a_accept;
    logic              wen_a_reg, ren_a_reg, busy_a_reg;
    logic              rd_done_reg, wr_done_reg, req_err_reg;
    logic [ADDR_W-1:0] addr_a_reg;
    logic [DATA_W-1:0] wdata_a_reg, mdr_out_reg;

    // Exactly one of rd_req/wr_req in IDLE starts an operation; both is an error.
    assign a_accept = (a_state_reg == A_IDLE) && (rd_req ^ wr_req);

    // Port A next-state logic; requests outside IDLE are simply not looked at.
    always_comb begin
        a_state_next = a_state_reg;
        a_cnt_next   = a_cnt_reg;
        a_capture    = 1'b0;
        case (a_state_reg)
            A_IDLE: begin
                if (rd_req && !wr_req)      a_state_next = A_RD_ISSUE;
                else if (wr_req && !rd_req) a_state_next = A_WR_ISSUE;
            end
            A_RD_ISSUE: begin
                a_state_next = A_RD_WAIT;
                a_cnt_next   = 3'd0;
            end
            A_RD_WAIT: begin
                if (a_cnt_reg == LAST_WAIT) begin
                    a_state_next = A_IDLE;
                    a_capture    = 1'b1;
                end else begin
                    a_cnt_next = a_cnt_reg + 3'd1;
                end
            end
            A_WR_ISSUE: a_state_next = A_IDLE;
            default:    a_state_next = A_IDLE;
        endcase
    end

    // Port A state and registered outputs, all decoded from the next state so
    // strobes and busy line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_state_reg <= A_IDLE;
            a_cnt_reg   <= 3'd0;
            wen_a_reg   <= 1'b0;
            ren_a_reg   <= 1'b0;
            busy_a_reg  <= 1'b0;
            rd_done_reg <= 1'b0;
            wr_done_reg <= 1'b0;
            req_err_reg <= 1'b0;
            addr_a_reg  <= '0;
            wdata_a_reg <= '0;
            mdr_out_reg <= '0;
        end else begin
            a_state_reg <= a_state_next;
            a_cnt_reg   <= a_cnt_next;
            ren_a_reg   <= (a_state_next == A_RD_ISSUE);
            wen_a_reg   <= (a_state_next == A_WR_ISSUE);
            busy_a_reg  <= (a_state_next != A_IDLE);
            rd_done_reg <= a_capture;
            wr_done_reg <= (a_state_reg == A_WR_ISSUE);
            req_err_reg <= (a_state_reg == A_IDLE) && rd_req && wr_req;
            if (a_accept) begin
                addr_a_reg <= mar;
                if (wr_req) wdata_a_reg <= mdr_in;
            end
            if (a_capture) mdr_out_reg <= rdata_A;
        end
    end

    assign wen_A   = wen_a_reg;
    assign ren_A   = ren_a_reg;
    assign busy_A  = busy_a_reg;
    assign rd_done = rd_done_reg;
    assign wr_done = wr_done_reg;
    assign req_err = req_err_reg;
    assign addr_A  = addr_a_reg;
    assign wdata_A = wdata_a_reg;
    assign mdr_out = mdr_out_reg;

`ifdef MEM_INITIATOR_FETCH_EN
    typedef enum logic [1:0] {B_IDLE, B_F_ISSUE, B_F_WAIT} b_state_t;

    b_state_t          b_state_reg, b_state_next;
    logic [2:0]        b_cnt_reg, b_cnt_next;
    logic              b_capture;
    logic              ren_b_reg, busy_b_reg, fetch_done_reg;
    logic [ADDR_W-1:0] addr_b_reg;
    logic [DATA_W-1:0] mbr_out_reg;

    // Port B next-state logic: same read sequence as port A, fetch only.
    always_comb begin
        b_state_next = b_state_reg;
        b_cnt_next   = b_cnt_reg;
        b_capture    = 1'b0;
        case (b_state_reg)
            B_IDLE:    if (fetch_req) b_state_next = B_F_ISSUE;
            B_F_ISSUE: begin
                b_state_next = B_F_WAIT;
                b_cnt_next   = 3'd0;
            end
            B_F_WAIT: begin
                if (b_cnt_reg == LAST_WAIT) begin
                    b_state_next = B_IDLE;
                    b_capture    = 1'b1;
                end else begin
                    b_cnt_next = b_cnt_reg + 3'd1;
                end
            end
            default:   b_state_next = B_IDLE;
        endcase
    end

    // Port B state and registered outputs, independent of port A.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_state_reg    <= B_IDLE;
            b_cnt_reg      <= 3'd0;
            ren_b_reg      <= 1'b0;
            busy_b_reg     <= 1'b0;
            fetch_done_reg <= 1'b0;
            addr_b_reg     <= '0;
            mbr_out_reg    <= '0;
        end else begin
            b_state_reg    <= b_state_next;
            b_cnt_reg      <= b_cnt_next;
            ren_b_reg      <= (b_state_next == B_F_ISSUE);
            busy_b_reg     <= (b_state_next != B_IDLE);
            fetch_done_reg <= b_capture;
            if (b_state_reg == B_IDLE && fetch_req) addr_b_reg <= pc;
            if (b_capture) mbr_out_reg <= rdata_B;
        end
    end

    assign ren_B      = ren_b_reg;
    assign busy_B     = busy_b_reg;
    assign fetch_done = fetch_done_reg;
    assign addr_B     = addr_b_reg;
    assign mbr_out    = mbr_out_reg;
`else
    // Fetch path absent: port B is quiet and its inputs are intentionally unused.
    logic unused_fetch;
    assign unused_fetch = ^{fetch_req, pc, rdata_B};
    assign ren_B      = 1'b0;
    assign busy_B     = 1'b0;
    assign fetch_done = 1'b0;
    assign addr_B     = '0;
    assign mbr_out    = '0;
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: drives two mem_initiator instances (RD_LAT=1 and RD_LAT=3)
// from the same request stream, each attached to its own behavioural memory,
// and checks every output cycle by cycle against the request timing rules.
module tb_mem_initiator;
    localparam int AW = 9;
    localparam int DW = 9;
`ifdef MEM_INITIATOR_FETCH_EN
    localparam bit FETCH_EN = 1'b1;
`else
    localparam bit FETCH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, preload;
    logic          rd_req, wr_req, fetch_req;
    logic [AW-1:0] mar, pc;
    logic [DW-1:0] mdr_in;

    logic          wen_A_o [2], ren_A_o [2], ren_B_o [2];
    logic [AW-1:0] addr_A_o [2], addr_B_o [2];
    logic [DW-1:0] wdata_A_o [2], rdata_A_i [2], rdata_B_i [2];
    logic [DW-1:0] mdr_out_o [2], mbr_out_o [2];
    logic          busy_A_o [2], busy_B_o [2], rd_done_o [2], wr_done_o [2];
    logic          fetch_done_o [2], req_err_o [2];

    int checks = 0;
    int errors = 0;

    // One DUT plus a dual-port memory with RD_LAT-stage read pipeline per latency.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dev
        localparam int L = (gi == 0) ? 1 : 3;
        logic [DW-1:0] mem [512];
        logic [DW-1:0] pa [4];
        logic [DW-1:0] pb [4];

        mem_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
            .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
            .fetch_req(fetch_req), .mar(mar), .pc(pc), .mdr_in(mdr_in),
            .wen_A(wen_A_o[gi]), .ren_A(ren_A_o[gi]), .ren_B(ren_B_o[gi]),
            .addr_A(addr_A_o[gi]), .addr_B(addr_B_o[gi]), .wdata_A(wdata_A_o[gi]),
            .rdata_A(rdata_A_i[gi]), .rdata_B(rdata_B_i[gi]),
            .mdr_out(mdr_out_o[gi]), .mbr_out(mbr_out_o[gi]),
            .busy_A(busy_A_o[gi]), .busy_B(busy_B_o[gi]), .rd_done(rd_done_o[gi]),
            .wr_done(wr_done_o[gi]), .fetch_done(fetch_done_o[gi]), .req_err(req_err_o[gi])
        );

        // Memory device: preload, write port A, pipelined reads on both ports.
        always @(posedge clk) begin
            if (preload) begin
                for (int i = 0; i < 512; i++) mem[i] <= '0;
                mem[5] <= 9'h0AA;
                mem[6] <= 9'h0BB;
                mem[9] <= 9'h0EE;
            end else if (wen_A_o[gi]) begin
                mem[addr_A_o[gi]] <= wdata_A_o[gi];
            end
            pa[0] <= ren_A_o[gi] ? mem[addr_A_o[gi]] : 9'h155;
            pb[0] <= ren_B_o[gi] ? mem[addr_B_o[gi]] : 9'h12A;
            for (int i = 1; i < 4; i++) begin
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end
        assign rdata_A_i[gi] = pa[L-1];
        assign rdata_B_i[gi] = pb[L-1];
    end

    // Reference memory contents as seen by the request stream.
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] exp_mdr [2];
    logic [DW-1:0] exp_mbr [2];

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    // Check every output of both DUTs against the quiet/idle values.
    task automatic chk_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, " ren_A"}, d, int'(ren_A_o[d]), 0);
            chk({tag, " wen_A"}, d, int'(wen_A_o[d]), 0);
            chk({tag, " busy_A"}, d, int'(busy_A_o[d]), 0);
            chk({tag, " rd_done"}, d, int'(rd_done_o[d]), 0);
            chk({tag, " ren_B"}, d, int'(ren_B_o[d]), 0);
            chk({tag, " fetch_done"}, d, int'(fetch_done_o[d]), 0);
            chk({tag, " mdr_out"}, d, int'(mdr_out_o[d]), int'(exp_mdr[d]));
            chk({tag, " mbr_out"}, d, int'(mbr_out_o[d]), int'(exp_mbr[d]));
        end
    endtask

    // kind: 0 idle, 1 read, 2 write, 3 read+write conflict. Request pulses in
    // cycle 0; cycles 1..6 are checked against the timing rules for latency L.
    task automatic run_op(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] dat,
                          input bit f, input logic [AW-1:0] p,
                          input logic [DW-1:0] exp_rd, input logic [DW-1:0] exp_f);
        int L;
        bit rd, wr, cf;
        @(negedge clk);
        rd = (kind == 1); wr = (kind == 2); cf = (kind == 3);
        rd_req = rd || cf; wr_req = wr || cf; mar = a; mdr_in = dat;
        fetch_req = f; pc = p;
        $display("op kind=%0d mar=%0h mdr_in=%0h fetch=%0d pc=%0h", kind, a, dat, f, p);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rd_req = 1'b0; wr_req = 1'b0; fetch_req = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                L = (d == 0) ? 1 : 3;
                if (rd && k == L + 2) exp_mdr[d] = exp_rd;
                if (f && FETCH_EN && k == L + 2) exp_mbr[d] = exp_f;
                chk("ren_A", d, int'(ren_A_o[d]), int'(rd && k == 1));
                chk("wen_A", d, int'(wen_A_o[d]), int'(wr && k == 1));
                chk("busy_A", d, int'(busy_A_o[d]),
                    int'((rd && k <= L + 1) || (wr && k == 1)));
                chk("rd_done", d, int'(rd_done_o[d]), int'(rd && k == L + 2));
                chk("wr_done", d, int'(wr_done_o[d]), int'(wr && k == 2));
                chk("req_err", d, int'(req_err_o[d]), int'(cf && k == 1));
                chk("ren_B", d, int'(ren_B_o[d]), int'(FETCH_EN && f && k == 1));
                chk("busy_B", d, int'(busy_B_o[d]), int'(FETCH_EN && f && k <= L + 1));
                chk("fetch_done", d, int'(fetch_done_o[d]), int'(FETCH_EN && f && k == L + 2));
                chk("mdr_out", d, int'(mdr_out_o[d]), int'(exp_mdr[d]));
                chk("mbr_out", d, int'(mbr_out_o[d]), int'(exp_mbr[d]));
                if ((rd || wr) && k == 1) chk("addr_A", d, int'(addr_A_o[d]), int'(a));
                if (wr && k == 1) chk("wdata_A", d, int'(wdata_A_o[d]), int'(dat));
                if (f && k == 1) chk("addr_B", d, int'(addr_B_o[d]), FETCH_EN ? int'(p) : 0);
            end
        end
        if (wr) ref_mem[a] = dat;
    endtask

    typedef struct {
        int            kind;
        logic [AW-1:0] a;
        logic [DW-1:0] dat;
        bit            f;
        logic [AW-1:0] p;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_f;
    } vec_t;

    vec_t tbl [8];

    initial begin
        rst = 1'b1; preload = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0; fetch_req = 1'b0;
        mar = '0; pc = '0; mdr_in = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        ref_mem[5] = 9'h0AA; ref_mem[6] = 9'h0BB; ref_mem[9] = 9'h0EE;
        exp_mdr[0] = '0; exp_mdr[1] = '0; exp_mbr[0] = '0; exp_mbr[1] = '0;

        tbl[0] = '{1, 9'd5, 9'h000, 1'b0, 9'd0, 9'h0AA, 9'h000};
        tbl[1] = '{2, 9'd7, 9'h0CC, 1'b0, 9'd0, 9'h000, 9'h000};
        tbl[2] = '{1, 9'd7, 9'h000, 1'b0, 9'd0, 9'h0CC, 9'h000};
        tbl[3] = '{3, 9'd7, 9'h011, 1'b0, 9'd0, 9'h000, 9'h000};
        tbl[4] = '{1, 9'd7, 9'h000, 1'b0, 9'd0, 9'h0CC, 9'h000};
        tbl[5] = '{1, 9'd9, 9'h000, 1'b1, 9'd6, 9'h0EE, 9'h0BB};
        tbl[6] = '{0, 9'd0, 9'h000, 1'b1, 9'd5, 9'h000, 9'h0AA};
        tbl[7] = '{3, 9'd9, 9'h001, 1'b1, 9'd7, 9'h000, 9'h0CC};

        repeat (3) @(negedge clk);
        $display("reset state");
        chk_quiet("reset");
        for (int d = 0; d < 2; d++) begin
            chk("reset addr_A", d, int'(addr_A_o[d]), 0);
            chk("reset wdata_A", d, int'(wdata_A_o[d]), 0);
            chk("reset addr_B", d, int'(addr_B_o[d]), 0);
            chk("reset req_err", d, int'(req_err_o[d]), 0);
        end
        rst = 1'b0; preload = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].kind, tbl[i].a, tbl[i].dat, tbl[i].f, tbl[i].p,
                   tbl[i].exp_rd, tbl[i].exp_f);

        // Reset in cycle 2 of a read aborts it in both latencies.
        @(negedge clk);
        rd_req = 1'b1; mar = 9'd5;
        $display("op reset-mid-read mar=5");
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_mdr[0] = '0; exp_mdr[1] = '0; exp_mbr[0] = '0; exp_mbr[1] = '0;
        repeat (5) begin
            chk_quiet("abort");
            @(negedge clk);
        end

`ifndef MEM_INITIATOR_FETCH_EN
        // Without the fetch path a held fetch request must do nothing.
        fetch_req = 1'b1; pc = 9'd6;
        $display("op fetch-held pc=6 (fetch path absent)");
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("nofetch ren_B", d, int'(ren_B_o[d]), 0);
                chk("nofetch fetch_done", d, int'(fetch_done_o[d]), 0);
                chk("nofetch mbr_out", d, int'(mbr_out_o[d]), 0);
            end
        end
        fetch_req = 1'b0;
`endif

        // Random request stream against the reference memory.
        for (int n = 0; n < 60; n++) begin
            int            kind;
            logic [AW-1:0] a, p;
            logic [DW-1:0] dat;
            bit            f;
            kind = int'($urandom_range(0, 3));
            a    = AW'($urandom_range(0, 15));
            p    = AW'($urandom_range(0, 15));
            dat  = DW'($urandom);
            f    = (kind != 2) && ($urandom_range(0, 1) == 1);
            run_op(kind, a, dat, f, p, ref_mem[a], ref_mem[p]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
